// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage between EX/MEM and MEM/WB.
// Single-outstanding req/ack bus, big-endian byte lanes, load sign/zero extension.
// Ports:
//   clk, rst (sync, active-high)
//   ex_*  : instruction in MEM (wd, wreg, wdata, memop, addr, sdata)
//   bus_* : registered req/we/addr/sel/wdata out; ack/rdata in
//   mem_* : result to MEM/WB; stallreq to pipeline control
//   bus_err : one-cycle pulse on timeout abort
//   excp_misalign : misaligned access flag
// Option macro LSU_ALIGN_CHECK_EN enables misalignment detection.
module mem_lsu #(
   parameter int REG_AW  = 5,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [3:0]        ex_memop,
   input  logic [31:0]       ex_addr,
   input  logic [DATA_W-1:0] ex_sdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [31:0]       bus_addr,
   output logic [3:0]        bus_sel,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [REG_AW-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stallreq,
   output logic              bus_err,
   output logic              excp_misalign
);

   localparam int CNT_W = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        sel_q, sel_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic              err_q, err_d;

   logic is_ld, is_st, is_byte, is_half, is_word, is_sgn, is_mem, misal;
   logic [3:0]        sel;
   logic [DATA_W-1:0] wdat, ld_val;
   logic [7:0]        lb;
   logic [15:0]       lh;

   always_comb begin
      is_ld   = 1'b0;
      is_st   = 1'b0;
      is_byte = 1'b0;
      is_half = 1'b0;
      is_word = 1'b0;
      is_sgn  = 1'b0;
      case (ex_memop)
         4'd1: begin is_ld = 1'b1; is_byte = 1'b1; is_sgn = 1'b1; end
         4'd2: begin is_ld = 1'b1; is_byte = 1'b1; end
         4'd3: begin is_ld = 1'b1; is_half = 1'b1; is_sgn = 1'b1; end
         4'd4: begin is_ld = 1'b1; is_half = 1'b1; end
         4'd5: begin is_ld = 1'b1; is_word = 1'b1; end
         4'd6: begin is_st = 1'b1; is_byte = 1'b1; end
         4'd7: begin is_st = 1'b1; is_half = 1'b1; end
         4'd8: begin is_st = 1'b1; is_word = 1'b1; end
         default: ;
      endcase
      is_mem = is_ld | is_st;
   end

`ifdef LSU_ALIGN_CHECK_EN
   assign misal = is_mem & ((is_half & ex_addr[0]) |
                            (is_word & (|ex_addr[1:0])));
`else
   assign misal = 1'b0;
`endif

   // Lane select and store replication; half lanes follow addr[1] only.
   always_comb begin
      sel  = 4'b1111;
      wdat = ex_sdata;
      if (is_byte) begin
         sel  = 4'b1000 >> ex_addr[1:0];
         wdat = {4{ex_sdata[7:0]}};
      end else if (is_half) begin
         sel  = ex_addr[1] ? 4'b0011 : 4'b1100;
         wdat = {2{ex_sdata[15:0]}};
      end
   end

   // Big-endian extraction: offset 0 is bits [31:24].
   always_comb begin
      case (ex_addr[1:0])
         2'd0:    lb = bus_rdata[31:24];
         2'd1:    lb = bus_rdata[23:16];
         2'd2:    lb = bus_rdata[15:8];
         default: lb = bus_rdata[7:0];
      endcase
      lh = ex_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
      if (is_byte)
         ld_val = is_sgn ? {{24{lb[7]}}, lb} : {24'b0, lb};
      else if (is_half)
         ld_val = is_sgn ? {{16{lh[15]}}, lh} : {16'b0, lh};
      else
         ld_val = bus_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      res_d         = res_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      sel_d         = sel_q;
      wdat_d        = wdat_q;
      err_d         = 1'b0;
      mem_wd        = ex_wd;
      mem_wreg      = 1'b0;
      mem_wdata     = ex_wdata;
      stallreq      = 1'b0;
      excp_misalign = 1'b0;
      case (state_q)
         IDLE: begin
            if (!is_mem) begin
               mem_wreg = ex_wreg;
            end else if (misal) begin
               excp_misalign = 1'b1;
            end else begin
               stallreq = 1'b1;
               state_d  = BUSY;
               cnt_d    = '0;
               req_d    = 1'b1;
               we_d     = is_st;
               addr_d   = {ex_addr[31:2], 2'b00};
               sel_d    = sel;
               wdat_d   = is_st ? wdat : '0;
            end
         end
         BUSY: begin
            stallreq = 1'b1;
            if (bus_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (is_ld)
                  res_d = ld_val;
            end else if (TIMEOUT != 0 &&
                         cnt_q == CNT_W'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // err_q is high only in the DONE cycle after an abort.
            mem_wreg = is_ld & ex_wreg & ~err_q;
            if (is_ld)
               mem_wdata = res_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         mem_wd        = '0;
         mem_wreg      = 1'b0;
         mem_wdata     = '0;
         stallreq      = 1'b0;
         excp_misalign = 1'b0;
      end
   end

   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_sel   = sel_q;
   assign bus_wdata = wdat_q;
   assign bus_err   = err_q & ~rst;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed-vector bench for mem_lsu.
// Bus responder driven per access; expected values computed by hand.
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_addr;
   logic [31:0] ex_sdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;
   logic        bus_err;
   logic        excp_misalign;

   int n_vec = 0;
   int n_err = 0;

   int          stalls;
   int          busy_n;
   int          errs_seen;
   logic        done_ok;
   logic [3:0]  cap_sel;
   logic [31:0] cap_addr;
   logic        cap_we;
   logic [31:0] cap_wdata;

   mem_lsu #(
      .REG_AW (5),
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_memop     (ex_memop),
      .ex_addr      (ex_addr),
      .ex_sdata     (ex_sdata),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_sel      (bus_sel),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .stallreq     (stallreq),
      .bus_err      (bus_err),
      .excp_misalign(excp_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] wd,
                        input logic wr, input logic [31:0] wdat);
      @(posedge clk);
      #1;
      ex_memop = op;
      ex_addr  = addr;
      ex_sdata = sd;
      ex_wd    = wd;
      ex_wreg  = wr;
      ex_wdata = wdat;
   endtask

   // Runs one access from IDLE; returns at the negedge of the DONE cycle.
   task automatic run_op(input int waits, input logic [31:0] rd);
      stalls    = 0;
      busy_n    = 0;
      errs_seen = 0;
      done_ok   = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (bus_err) errs_seen++;
         if (!stallreq) begin
            done_ok = 1'b1;
            break;
         end
         stalls++;
         if (bus_req) begin
            busy_n++;
            if (busy_n == 1) begin
               cap_sel   = bus_sel;
               cap_addr  = bus_addr;
               cap_we    = bus_we;
               cap_wdata = bus_wdata;
            end
            if (busy_n == waits + 1) begin
               bus_ack   = 1'b1;
               bus_rdata = rd;
            end
         end
      end
      chk("access_done", {31'b0, done_ok}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      ex_memop  = 4'd0;
      ex_addr   = '0;
      ex_sdata  = '0;
      ex_wd     = 5'd5;
      ex_wreg   = 1'b1;
      ex_wdata  = 32'hDEAD0001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wd", {27'b0, mem_wd}, 32'd0);
      chk("rst_wreg", {31'b0, mem_wreg}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_stall", {31'b0, stallreq}, 32'd0);
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_err", {31'b0, bus_err}, 32'd0);

      @(posedge clk);
      #1 rst = 1'b0;
      ex_wdata = 32'h1234;
      @(negedge clk);
      chk("alu_wd", {27'b0, mem_wd}, 32'd5);
      chk("alu_wreg", {31'b0, mem_wreg}, 32'd1);
      chk("alu_wdata", mem_wdata, 32'h1234);
      chk("alu_stall", {31'b0, stallreq}, 32'd0);

      start(4'd12, 32'h1000, 32'h0, 5'd6, 1'b1, 32'h42);
      @(negedge clk);
      chk("op12_stall", {31'b0, stallreq}, 32'd0);
      chk("op12_wdata", mem_wdata, 32'h42);
      @(negedge clk);
      chk("op12_req", {31'b0, bus_req}, 32'd0);

      start(4'd1, 32'h1001, 32'h0, 5'd7, 1'b1, 32'h55);
      run_op(0, 32'h11803344);
      chk("lb_stalls", stalls, 32'd2);
      chk("lb_sel", {28'b0, cap_sel}, 32'b0100);
      chk("lb_addr", cap_addr, 32'h1000);
      chk("lb_we", {31'b0, cap_we}, 32'd0);
      chk("lb_wd", {27'b0, mem_wd}, 32'd7);
      chk("lb_wreg", {31'b0, mem_wreg}, 32'd1);
      chk("lb_data", mem_wdata, 32'hFFFFFF80);

      start(4'd2, 32'h1001, 32'h0, 5'd7, 1'b1, 32'h55);
      run_op(0, 32'h11803344);
      chk("lbu_data", mem_wdata, 32'h00000080);

      start(4'd3, 32'h1002, 32'h0, 5'd8, 1'b1, 32'h0);
      run_op(0, 32'h11803344);
      chk("lh2_sel", {28'b0, cap_sel}, 32'b0011);
      chk("lh2_data", mem_wdata, 32'h00003344);

      start(4'd3, 32'h1000, 32'h0, 5'd8, 1'b1, 32'h0);
      run_op(1, 32'h8001ABCD);
      chk("lh0_stalls", stalls, 32'd3);
      chk("lh0_sel", {28'b0, cap_sel}, 32'b1100);
      chk("lh0_data", mem_wdata, 32'hFFFF8001);

      start(4'd4, 32'h1000, 32'h0, 5'd8, 1'b1, 32'h0);
      run_op(0, 32'h8001ABCD);
      chk("lhu_data", mem_wdata, 32'h00008001);

      start(4'd5, 32'h1004, 32'h0, 5'd9, 1'b1, 32'h0);
      run_op(2, 32'hCAFEF00D);
      chk("lw_stalls", stalls, 32'd4);
      chk("lw_sel", {28'b0, cap_sel}, 32'b1111);
      chk("lw_addr", cap_addr, 32'h1004);
      chk("lw_data", mem_wdata, 32'hCAFEF00D);

      start(4'd7, 32'h2002, 32'hAAAABEEF, 5'd10, 1'b1, 32'h0);
      run_op(3, 32'h0);
      chk("sh_stalls", stalls, 32'd5);
      chk("sh_we", {31'b0, cap_we}, 32'd1);
      chk("sh_sel", {28'b0, cap_sel}, 32'b0011);
      chk("sh_addr", cap_addr, 32'h2000);
      chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
      chk("sh_wreg", {31'b0, mem_wreg}, 32'd0);

      start(4'd6, 32'h2003, 32'h12345678, 5'd10, 1'b1, 32'h0);
      run_op(0, 32'h0);
      chk("sb_sel", {28'b0, cap_sel}, 32'b0001);
      chk("sb_wdata", cap_wdata, 32'h78787878);
      chk("sb_wreg", {31'b0, mem_wreg}, 32'd0);

      start(4'd8, 32'h2008, 32'h0BADF00D, 5'd10, 1'b1, 32'h0);
      run_op(0, 32'h0);
      chk("sw_sel", {28'b0, cap_sel}, 32'b1111);
      chk("sw_wdata", cap_wdata, 32'h0BADF00D);

      start(4'd5, 32'h3000, 32'h0, 5'd11, 1'b1, 32'h0);
      run_op(99, 32'h0);
      chk("to_stalls", stalls, 32'd5);
      chk("to_err", errs_seen, 32'd1);
      chk("to_wreg", {31'b0, mem_wreg}, 32'd0);
      start(4'd0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h99);
      @(negedge clk);
      chk("to_err_low", {31'b0, bus_err}, 32'd0);
      chk("to_idle_stall", {31'b0, stallreq}, 32'd0);
      chk("to_idle_wreg", {31'b0, mem_wreg}, 32'd1);

`ifdef LSU_ALIGN_CHECK_EN
      start(4'd5, 32'h3002, 32'h0, 5'd13, 1'b1, 32'h0);
      @(negedge clk);
      chk("mis_excp", {31'b0, excp_misalign}, 32'd1);
      chk("mis_stall", {31'b0, stallreq}, 32'd0);
      chk("mis_wreg", {31'b0, mem_wreg}, 32'd0);
      @(negedge clk);
      chk("mis_req", {31'b0, bus_req}, 32'd0);
`else
      start(4'd5, 32'h3002, 32'h0, 5'd13, 1'b1, 32'h0);
      run_op(0, 32'h01020304);
      chk("mis_excp", {31'b0, excp_misalign}, 32'd0);
      chk("mis_stalls", stalls, 32'd2);
      chk("mis_sel", {28'b0, cap_sel}, 32'b1111);
      chk("mis_addr", cap_addr, 32'h3000);
      chk("mis_data", mem_wdata, 32'h01020304);
`endif

      start(4'd5, 32'h4000, 32'h0, 5'd3, 1'b1, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rb_req_busy", {31'b0, bus_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rb_stall", {31'b0, stallreq}, 32'd0);
      chk("rb_wreg", {31'b0, mem_wreg}, 32'd0);
      chk("rb_wdata", mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      ex_memop  = 4'd0;
      ex_wd     = 5'd9;
      ex_wreg   = 1'b1;
      ex_wdata  = 32'h77;
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE;
      @(negedge clk);
      chk("rb_req_drop", {31'b0, bus_req}, 32'd0);
      chk("rb_idle_stall", {31'b0, stallreq}, 32'd0);
      chk("rb_idle_data", mem_wdata, 32'h77);
      @(posedge clk);
      #1 bus_ack = 1'b0;
      @(negedge clk);
      chk("rb_late_data", mem_wdata, 32'h77);
      chk("rb_late_req", {31'b0, bus_req}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs loads and stores over a single-outstanding req/ack data bus.
- Extracts bytes and halfwords (big-endian lanes) and sign- or zero-extends them.
- Asserts a stall request while a bus access is in flight. Drives mem_wd/mem_wreg/mem_wdata into the MEM/WB register.

Parameters:
- REG_AW, 5, register-file address width
- DATA_W, 32, data and bus width (fixed at 32; byte-lane logic assumes 4 lanes)
- TIMEOUT, 255, BUSY cycles without bus_ack before the access is aborted (0 = never)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_wd  in  REG_AW  destination register of the instruction in MEM
- ex_wreg  in  1  write-enable of that instruction
- ex_wdata  in  DATA_W  ALU result (passed through for non-memory ops)
- ex_memop  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9-15 treated as none
- ex_addr  in  32  effective byte address
- ex_sdata  in  DATA_W  store data (rt value)
- bus_req  out  1  access request (registered)
- bus_we  out  1  1=write (registered)
- bus_addr  out  32  word address, bits[1:0]=0 (registered)
- bus_sel  out  4  byte enables, bit3=bits[31:24] (registered)
- bus_wdata  out  DATA_W  write data (registered)
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- mem_wd  out  REG_AW  to MEM/WB
- mem_wreg  out  1  to MEM/WB
- mem_wdata  out  DATA_W  to MEM/WB
- stallreq  out  1  to pipeline control; freezes PC..EX/MEM and bubbles MEM/WB
- bus_err  out  1  one-cycle pulse on timeout abort
- excp_misalign  out  1  misaligned access (see Optional Feature)

Behaviour:
- Reset:
  - FSM to IDLE; all registered bus outputs 0; timeout counter 0; result register 0.
  - While rst=1, mem_wd=0, mem_wreg=0, mem_wdata=0, stallreq=0, bus_err=0.
  - Reset mid-access drops bus_req at that edge; a late bus_ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-memory op:
  - mem_* = ex_* combinationally; stallreq=0; stays IDLE.
- IDLE, memory op:
  - stallreq=1 combinationally; mem_wreg=0.
  - Next edge: load bus_* and enter BUSY.
  - bus_addr = {ex_addr[31:2],2'b00}.
  - Lanes are big-endian:
    - byte: offset 0→sel 1000, 1→0100, 2→0010, 3→0001.
    - half: offset 0→1100, 2→0011.
    - word: sel 1111.
  - Store data replicated to all lanes: SB {4{b}}, SH {2{h}}, SW as is.
- BUSY:
  - bus_req held 1; stallreq=1; counter increments each cycle.
  - On bus_ack: bus_req←0 at that edge, capture the extracted/extended load result (stores capture nothing), enter DONE.
  - If the counter reaches TIMEOUT first: bus_req←0, bus_err pulses 1 cycle, enter DONE with mem_wreg forced 0.
- DONE (exactly 1 cycle):
  - stallreq=0; mem_wd=ex_wd.
  - Loads: mem_wreg=ex_wreg, mem_wdata=captured result.
  - Stores: mem_wreg=0.
  - Next edge: IDLE. The pipeline advances, so the next instruction is seen in IDLE.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW uses the word as is.
- Latency: an ack in the first BUSY cycle gives 2 stall cycles. Each extra wait cycle adds 1.
- Inputs must stay stable while stallreq=1 (the upstream register holds them). The block does not re-sample them.
- Back-to-back memory ops: the second starts its own IDLE→BUSY sequence; there are no idle bus cycles beyond DONE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned access issues no bus request and causes no stall.
  - excp_misalign=1 combinationally in IDLE that cycle; mem_wreg=0.
- Not defined:
  - excp_misalign tied 0.
  - Low address bits are ignored for lane selection: half uses addr[1], word uses sel 1111.

Test Plan:
- Reset with bus_req=1 in BUSY → next edge bus_req=0, FSM IDLE, all mem_* 0; a later bus_ack causes no write.
- ALU op, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 → same cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234, stallreq=0.
- LB addr=0x1001, ack in the first BUSY cycle with rdata=0x11803344:
  - bus_sel=0100, bus_addr=0x1000.
  - stallreq high 2 cycles.
  - DONE mem_wdata=0xFFFFFF80.
  - Same with LBU → 0x00000080.
- SH addr=0x2002, sdata=0xAAAABEEF, ack after 3 wait cycles → bus_we=1, sel=0011, wdata=0xBEEFBEEF, stall 5 cycles, DONE mem_wreg=0.
- TIMEOUT=4, LW with no ack → bus_err pulses after 4 BUSY cycles, DONE mem_wreg=0, FSM returns to IDLE.
- With LSU_ALIGN_CHECK_EN, LW addr=0x3002 → excp_misalign=1, bus_req never asserted, stallreq=0.
